// File: rtl/countdown_timer.sv
// Loadable down-counter with an IDLE/RUN/PAUSE controller and a one-cycle done pulse.
// Optional auto-reload on expiry: define COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer #(
  parameter int N = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_d;
  logic         done_d;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [N-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      paused   <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      done     <= done_d;
      busy     <= (state_d == RUN);
      paused   <= (state_d == PAUSE);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    done_d   = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      count_d  = load_val;
      state_d  = IDLE;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // stop outranks start, so a simultaneous pair leaves the timer idle
          if (!stop && start && (count != '0)) state_d = RUN;
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (en) begin
            if (count == N'(1)) begin
              done_d  = 1'b1;
              count_d = '0;
              state_d = IDLE;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
              if (reload_q != '0) begin
                count_d = reload_q;
                state_d = RUN;
              end
`endif
            end else begin
              count_d = count - N'(1);
            end
          end
        end
        PAUSE: begin
          if (!stop && start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_countdown_timer;
  localparam int N = 20;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] count;
  logic         busy, paused, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model: how many ticks remain, whether running / paused, pulse flag
  longint m_count  = 0;
  longint m_reload = 0;
  bit     m_run    = 1'b0;
  bit     m_pause  = 1'b0;
  bit     m_done   = 1'b0;

  countdown_timer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .en(en),
    .count(count), .busy(busy), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_run = 0; m_pause = 0; m_done = 0;
  endtask

  task automatic model_step();
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      m_count = longint'(load_val);
      m_reload = longint'(load_val);
      m_run = 0; m_pause = 0;
    end else if (m_run) begin
      if (stop) begin
        m_run = 0; m_pause = 1;
      end else if (en) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_done = 1;
          if (AR && m_reload != 0) m_count = m_reload;
          else m_run = 0;
        end
      end
    end else if (m_pause) begin
      if (start && !stop) begin
        m_run = 1; m_pause = 0;
      end
    end else if (start && !stop && m_count != 0) begin
      m_run = 1;
    end
  endtask

  task automatic compare();
    chk("count",  longint'(count),  m_count);
    chk("busy",   longint'(busy),   longint'(m_run));
    chk("paused", longint'(paused), longint'(m_pause));
    chk("done",   longint'(done),   longint'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = N'(v); tick(); load = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_count", longint'(count), 0);
    chk("rst_busy",  longint'(busy),  0);
    chk("rst_done",  longint'(done),  0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    longint exp_seq[4];
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_count", longint'(count), 0);
    chk("reset_busy", longint'(busy), 0);

    // basic countdown
    do_load(4);
    en = 1;
    do_start();
    chk("start_busy", longint'(busy), 1);
    chk("start_count", longint'(count), 4);
    exp_seq = '{3, 2, 1, AR ? 4 : 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("basic_count", longint'(count), exp_seq[i]);
      chk("basic_done", longint'(done), (i == 3) ? 1 : 0);
    end
    if (!AR) chk("basic_busy_end", longint'(busy), 0);

    // pause and resume
    do_load(10);
    do_start();
    repeat (3) tick();
    stop = 1; tick(); stop = 0;
    repeat (5) tick();
    chk("pause_count", longint'(count), 7);
    chk("pause_flag", longint'(paused), 1);
    do_start();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("resume_done", longint'(done), (i == 6) ? 1 : 0);
    end

    // priority: load beats start; stop beats the final decrement
    load = 1; load_val = N'(3); start = 1; tick(); load = 0; start = 0;
    chk("prio_load_count", longint'(count), 3);
    chk("prio_load_busy", longint'(busy), 0);
    do_start();
    repeat (2) tick();
    stop = 1; tick(); stop = 0;
    chk("prio_stop_count", longint'(count), 1);
    chk("prio_stop_paused", longint'(paused), 1);
    chk("prio_stop_done", longint'(done), 0);

    // sparse enable
    en = 0;
    do_load(3);
    do_start();
    for (int i = 0; i < 12; i++) begin
      en = (i % 4 == 3);
      tick();
    end
    en = 0;
    chk("sparse_done", longint'(done), 1);
    chk("sparse_count", longint'(count), AR ? 3 : 0);

    // reset mid-run, then start is ignored at count 0
    do_load(5);
    en = 1;
    do_start();
    repeat (2) tick();
    chk("midrun_count", longint'(count), 3);
    async_reset();
    do_start();
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_count", longint'(count), 0);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    do_load(2);
    do_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_count", longint'(count), (i % 2 == 0) ? 1 : 2);
      chk("ar_done", longint'(done), (i % 2 == 1) ? 1 : 0);
    end
    do_load(0);
    do_start();
    chk("ar_zero_count", longint'(count), 0);
    chk("ar_zero_busy", longint'(busy), 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 19) == 0);
      load_val = N'($urandom_range(0, 12));
      start = ($urandom_range(0, 7) == 0);
      stop = !start && ($urandom_range(0, 15) == 0);
      en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 399) == 0) async_reset();
      else tick();
    end
    load = 0; start = 0; stop = 0; en = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a run/pause state machine: the counterpart to the free-running up-counter used elsewhere in the design. Software or a controller FSM loads a terminal count, starts it, and receives a one-cycle `done` pulse when the count reaches zero. It sits beside the up-counter in the timing subsystem and drives timeouts, debounce windows and periodic strobes. The `en` input is a tick enable, typically a prescaler strobe.

## Interface
- `N`, default 20: counter width in bits.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: load `load_val` into the counter (level-sampled each edge).
- `load_val`  in  N: value to load. Unsigned.
- `start`  in  1: begin or resume counting.
- `stop`  in  1: pause counting.
- `en`  in  1: tick enable. Decrements only on edges where this is high.
- `count`  out  N: current counter value (registered).
- `busy`  out  1: high while in RUN.
- `paused`  out  1: high while in PAUSE.
- `done`  out  1: one-cycle pulse on the cycle `count` reaches 0.

## Operation
- States: IDLE, RUN, PAUSE. On reset: state IDLE, `count`=0, `busy`=0, `paused`=0, `done`=0, reload register=0.
- Command priority per edge: `load` > `stop` > `start` > decrement.
- `load` in any state:
  - `count` ← `load_val`; reload register ← `load_val`.
  - State → IDLE.
  - No `done` is generated.
- IDLE:
  - `start` with `count`≠0 → RUN.
  - `start` with `count`=0 is ignored and stays IDLE.
  - `stop` is ignored.
- RUN:
  - `stop` → PAUSE, and `count` holds.
  - Otherwise, if `en`=1, `count` ← `count`−1.
  - The transition 1→0 asserts `done` for exactly one cycle, registered together with `count`=0, then applies the expiry behaviour (see Configuration).
  - `start` while in RUN is a no-op.
- PAUSE:
  - `count` holds regardless of `en`.
  - `start` → RUN. `stop` is a no-op.
- Arithmetic:
  - Unsigned N-bit.
  - Decrement never occurs at `count`=0, so there is no wrap to all-ones.
  - `load_val`=0 followed by `start` is ignored.
- `busy` = (state==RUN) and `paused` = (state==PAUSE). Both are registered, not decoded combinationally from inputs.

## Timing
- All outputs are registered and change only on the rising edge of `clk` or on assertion of `rst_n`.
- Reset:
  - Assertion clears all state immediately, including a `done` pulse in flight.
  - Deassertion is synchronized externally; the block is usable from the first edge after release.
- Start and first decrement:
  - `start` sampled at edge k → `busy`=1 after edge k.
  - `en` at edge k does not decrement; the first decrement is at the first edge >k with `en`=1.
- Latency to `done`: with `load_val`=L, `start` at edge k and `en` held high, `count`=0 and `done`=1 after edge k+L. `busy`=0 after that same edge when reload is disabled.
- Simultaneous events:
  - `load` with `start` on the same edge: load wins and the state is IDLE.
  - `stop` with the 1→0 decrement edge: stop wins, `count` stays at 1 in PAUSE, and no `done` is generated.
- `done` never asserts on two consecutive cycles unless auto-reload is on with reload value 1 and `en` held high.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTORELOAD_EN`.
- Defined:
  - On expiry in RUN, `count` ← reload register on the same edge that would have produced 0, and the state stays RUN. `done` still pulses for that cycle.
  - `count` reads the reload value, not 0, on the `done` cycle.
  - If the reload register is 0, the block behaves as non-reload: `count`=0 and state IDLE.
- Undefined:
  - On expiry, `count`=0 and state → IDLE.
  - The reload register is not synthesized; the `load` path writes `count` only.

## Test plan
- Reset mid-run:
  - Load 5, start, run 2 ticks.
  - Assert `rst_n`=0 asynchronously between edges → `count`=0, `busy`=0 and `done`=0 immediately.
  - After release, `start` is ignored because count is 0.
- Basic countdown:
  - Load 4, start at edge k, hold `en`=1.
  - `count` must read 3, 2, 1, 0 after edges k+1 through k+4.
  - `done`=1 only after k+4, and `busy`=0 after k+4 (reload off).
- Pause and resume:
  - Load 10, start, run 3 ticks, stop, hold `en`=1 for 5 cycles → `count` stays 7 and `paused`=1.
  - Start again → 7 more ticks to `done`.
- Priority:
  - `load`(3) and `start` on the same edge → `count`=3, IDLE.
  - `stop` on the 1→0 edge → `count`=1, PAUSE, no `done`.
- Sparse enable: load 3, start, `en` high every 4th cycle → `done` after the 3rd enabled tick (cycle 12). Count never wraps.
- Auto-reload (macro defined):
  - Load 2, start, `en`=1 → `done` pulses every 2 cycles, with `count` alternating 1, 2, 1, 2.
  - Load 0 mid-run → IDLE with `count`=0.
